// File: rtl/fpi2c_bitseq.sv
// fpi2c_bitseq - bit-level I2C sequencer for the front-panel I2C path.
//
// Takes one byte-level operation at a time (START, WRITE, READ, STOP) from
// the command engine and turns it into open-drain SCL/SDA activity. Each
// phase is four quarters of DIVIDER clocks. The result comes back with a
// one-cycle rspvalid pulse.
//
// Parameters:
//   DIVIDER  CLOCK cycles per quarter-bit (2..65535, 250 = 100 kHz @ 100 MHz)
//
// Ports:
//   CLOCK, RESET_N       system clock, asynchronous active-low reset
//   cmdvalid/cmdready    operation handshake, accepted when both high
//   cmdop                0=START, 1=WRITE, 2=READ, 3=STOP
//   cmdbyte              WRITE data, MSB first
//   cmdlast              READ only: 1 = NACK after the byte
//   rspvalid             one-cycle completion pulse
//   rspbyte              READ data, or the byte sent for WRITE
//   rspack               WRITE: slave ACKed; READ: master sent ACK
//   rsparb               arbitration lost on this operation
//   busy                 operation in progress
//   sclo, sdao           line drives, 1 = release, 0 = pull low
//   scli, sdai           pad readback
//
// Build option:
//   FPI2C_STRETCH_EN     when defined, the end of Q1 is held while scli is
//                        low (slave clock stretching, no timeout). When not
//                        defined scli is ignored.

module fpi2c_bitseq #(
  parameter int unsigned DIVIDER = 250
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       cmdvalid,
  output logic       cmdready,
  input  logic [1:0] cmdop,
  input  logic [7:0] cmdbyte,
  input  logic       cmdlast,
  output logic       rspvalid,
  output logic [7:0] rspbyte,
  output logic       rspack,
  output logic       rsparb,
  output logic       busy,
  output logic       sclo,
  output logic       sdao,
  input  logic       scli,
  input  logic       sdai
);

  // state   | meaning
  // --------+------------------------------------------------------------
  // S_IDLE  | waiting for an operation, lines hold their last value
  // S_START | start / repeated start: SDA released, SCL up, SDA down, SCL down
  // S_BIT   | one of nine bits of a WRITE or READ, four quarters each
  // S_STOP  | stop: SDA low, SCL up, SDA up, hold

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BIT   = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  localparam logic [15:0] QLOAD = 16'(DIVIDER - 1);

  logic [1:0]  state;
  logic [1:0]  quarter;
  logic [15:0] qcnt;
  logic [3:0]  bitnum;
  logic        rdop;
  logic        last;
  logic        ackbit;
  logic [7:0]  txbyte;
  logic [7:0]  rxbyte;
  logic        stretch;
  logic        nextbit;

  // SDA drive for bit n (0..8) of the current byte operation.
  function automatic logic bitval(input logic rd, input logic lst,
                                  input logic [7:0] tx, input logic [3:0] n);
    if (n == 4'd8) bitval = rd ? lst : 1'b1;
    else           bitval = rd ? 1'b1 : tx[3'd7 - n[2:0]];
  endfunction

  assign nextbit  = bitval(rdop, last, txbyte, bitnum + 4'd1);
  assign cmdready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

`ifdef FPI2C_STRETCH_EN
  // SCL was released at Q1 entry; do not move on to Q2 until it is seen high.
  assign stretch = (quarter == 2'd1) && !scli;
`else
  logic unused_scli;
  assign unused_scli = scli;
  assign stretch     = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      quarter  <= 2'd0;
      qcnt     <= 16'd0;
      bitnum   <= 4'd0;
      rdop     <= 1'b0;
      last     <= 1'b0;
      ackbit   <= 1'b0;
      txbyte   <= 8'd0;
      rxbyte   <= 8'd0;
      rspvalid <= 1'b0;
      rspbyte  <= 8'd0;
      rspack   <= 1'b0;
      rsparb   <= 1'b0;
      sclo     <= 1'b1;
      sdao     <= 1'b1;
    end else begin
      rspvalid <= 1'b0;
      if (state == S_IDLE) begin
        if (cmdvalid) begin
          quarter <= 2'd0;
          qcnt    <= QLOAD;
          bitnum  <= 4'd0;
          rsparb  <= 1'b0;
          txbyte  <= cmdbyte;
          last    <= cmdlast;
          rdop    <= (cmdop == OP_READ);
          // Q0 drive is applied on the accept edge.
          case (cmdop)
            OP_START: begin state <= S_START; sdao <= 1'b1;       end
            OP_WRITE: begin state <= S_BIT;   sdao <= cmdbyte[7]; end
            OP_READ:  begin state <= S_BIT;   sdao <= 1'b1;       end
            default:  begin state <= S_STOP;  sdao <= 1'b0;       end
          endcase
        end
      end else if (qcnt != 16'd0) begin
        qcnt <= qcnt - 16'd1;
      end else if (!stretch) begin
        qcnt    <= QLOAD;
        quarter <= quarter + 2'd1;
        case (quarter)
          2'd0: sclo <= 1'b1;
          2'd1: begin
            // entering Q2: SDA edge for START/STOP, sample point for bits
            if (state == S_START) sdao <= 1'b0;
            if (state == S_STOP)  sdao <= 1'b1;
            if (state == S_BIT) begin
              if (rdop) begin
                if (bitnum != 4'd8) rxbyte <= {rxbyte[6:0], sdai};
              end else if (bitnum == 4'd8) begin
                ackbit <= ~sdai;
              end else if (sdao && !sdai) begin
                // another master is holding SDA low: back off immediately
                state    <= S_IDLE;
                sclo     <= 1'b1;
                sdao     <= 1'b1;
                rsparb   <= 1'b1;
                rspvalid <= 1'b1;
                rspbyte  <= txbyte;
                rspack   <= 1'b0;
              end
            end
          end
          2'd2: if (state != S_STOP) sclo <= 1'b0;
          default: begin
            if (state == S_BIT && bitnum != 4'd8) begin
              bitnum <= bitnum + 4'd1;
              sdao   <= nextbit;
            end else begin
              state    <= S_IDLE;
              rspvalid <= 1'b1;
              if (state == S_BIT) begin
                rspbyte <= rdop ? rxbyte : txbyte;
                rspack  <= rdop ? ~last : ackbit;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fpi2c_bitseq.md
# fpi2c_bitseq

Bit-level I2C sequencer for the front-panel I2C path. It accepts one byte-level operation at a time (START, WRITE byte, READ byte, STOP) from the command-word engine over a valid/ready handshake. It drives open-drain SCL/SDA through quarter-bit timing and returns received data and ACK status. It sits directly between the front-panel command engine and the I2C pads, owning all wire-level timing.

## Interface

- DIVIDER, 250: CLOCK cycles per quarter-bit; 100 kHz SCL at 100 MHz; legal range 2..65535

- CLOCK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- cmdvalid  in  1  operation presented
- cmdready  out  1  sequencer idle, will accept operation
- cmdop  in  2  0=START (also repeated start), 1=WRITE, 2=READ, 3=STOP
- cmdbyte  in  8  WRITE data, MSB first
- cmdlast  in  1  READ only: 1 = send NACK after byte
- rspvalid  out  1  one-cycle pulse, operation complete
- rspbyte  out  8  READ data (WRITE: byte sent)
- rspack  out  1  WRITE: 1 = slave ACKed; READ: 1 = master ACK sent
- rsparb  out  1  arbitration lost on this operation
- busy  out  1  operation in progress
- sclo  out  1  SCL drive, 1 = release, 0 = pull low
- sdao  out  1  SDA drive, 1 = release, 0 = pull low
- scli  in  1  SCL pad readback
- sdai  in  1  SDA pad readback

## Operation

- States: IDLE, START, BIT, STOP. Every non-IDLE phase is four quarters Q0..Q3; quarter counter loads DIVIDER-1, steps on 0.
- IDLE: cmdready=1, busy=0; sclo/sdao hold last value (1/1 after reset or STOP, sclo=0 after START/WRITE/READ).
- START: Q0 sdao=1 (SCL low or already high); Q1 sclo=1; Q2 sdao=0; Q3 sclo=0. Same sequence for first and repeated start.
- WRITE: 9 bits in BIT state: bits 7..0 of cmdbyte, then ninth bit with sdao=1. Per bit: Q0 set sdao (SCL low); Q1 sclo=1; Q2 sample sdai; Q3 sclo=0. rspack = ~sdai sampled in ninth bit.
- READ: sdao=1 for bits 1..8, sdai sampled at Q2 shifts into rspbyte MSB first; ninth bit sdao = cmdlast (0 = ACK). rspack = ~cmdlast.
- STOP: Q0 sdao=0; Q1 sclo=1; Q2 sdao=1; Q3 hold. Ends with sclo=1, sdao=1.
- Arbitration: in WRITE data bits (1..8), sdao=1 but sdai sampled 0 at Q2: abort at once, sclo=1, sdao=1, rsparb=1, rspvalid pulse, return IDLE. START/STOP/ACK bits are not checked.
- No protocol ordering check: WRITE/READ without prior START executed as given; host responsibility.

## Timing

- Accept on cmdvalid & cmdready rising edge; busy=1, cmdready=0 from next cycle. cmdbyte/cmdlast latched at accept.
- START/STOP: 4*DIVIDER cycles accept-to-rspvalid. WRITE/READ: 36*DIVIDER cycles (plus stretch).
- rspvalid asserted one cycle on the edge returning to IDLE; cmdready=1 that same cycle; back-to-back accept possible that cycle.
- rspbyte/rspack/rsparb valid from rspvalid until next accept; rsparb cleared at accept.
- Reset values: cmdready=1, busy=0, rspvalid=0, rspbyte=0, rspack=0, rsparb=0, sclo=1, sdao=1.
- RESET_N low mid-operation: lines released immediately (asynchronous), operation lost, no rspvalid.

## Configuration

- FPI2C_STRETCH_EN defined: after sclo=1 in Q1, quarter counter holds at Q2 entry while scli=0 (slave clock stretching); sampling delayed until scli=1, no timeout.
- Undefined: scli ignored; fixed timing only.

## Test plan

- Reset then START, WRITE 0xA5 with slave ACK -> SDA transitions only while SCL low except start; rspack=1, rspbyte=0xA5, rspvalid at 36*DIVIDER cycles.
- READ cmdlast=0, slave drives 0x3C -> rspbyte=0x3C, ninth-bit sdao=0, rspack=1; repeat with cmdlast=1 -> ninth-bit sdao=1, rspack=0.
- WRITE 0x80 with no slave (sdai follows sdao, ninth bit reads 1) -> rspack=0, rsparb=0.
- WRITE 0xFF, other master pulls SDA low on bit 6 -> rsparb=1, sclo=sdao=1, rspvalid after bit 6 Q2.
- With FPI2C_STRETCH_EN, hold scli=0 for 1000 cycles on bit 3 -> completion delayed exactly 1000 cycles; without, no delay.
- Assert RESET_N low mid-READ -> sclo=sdao=1 same cycle, cmdready=1, no rspvalid; following START/STOP completes normally.
